// File: rtl/ddr_out_reg.sv
// ddr_out_reg: single-clock double-data-rate output register with sync set/reset
//   clk_in      : only clock; rising edge = E0, falling edge = E1
//   n_reset_in  : synchronous active-low reset, sampled at both edges, loads INIT
//   ce_in       : data-path clock enable (reset/set act regardless)
//   d0_in/d1_in : words driven in the clock-high / clock-low phase
//   r_in / s_in : synchronous output clear / set (clear wins)
//   q_out       : DDR output
module ddr_out_reg #(
    parameter int    W_DATA        = 1,
    parameter string DDR_ALIGNMENT = "NONE",
    parameter logic  INIT          = 1'b1
) (
    input  logic              clk_in,
    input  logic              n_reset_in,
    input  logic              ce_in,
    input  logic [W_DATA-1:0] d0_in,
    input  logic [W_DATA-1:0] d1_in,
    input  logic              r_in,
    input  logic              s_in,
    output logic [W_DATA-1:0] q_out
);
    localparam bit AL_C0 = DDR_ALIGNMENT == "C0";
    localparam bit AL_C1 = DDR_ALIGNMENT == "C1";
    localparam logic [W_DATA-1:0] INIT_W = {W_DATA{INIT}};
    // Each edge owns its own output register; the phase mux picks the one
    // written most recently, so q_out only moves right after an edge.
    logic [W_DATA-1:0] q_p = INIT_W;
    logic [W_DATA-1:0] q_n = INIT_W;
    // The holding register must be writable from both edges (sampling edge
    // and forcing at the other edge). Each edge keeps its own copy and a
    // toggle pair marks which copy is newest: equal = rising-edge copy.
    logic [W_DATA-1:0] h_p = INIT_W;
    logic [W_DATA-1:0] h_n = INIT_W;
    logic              t_p = 1'b0;
    logic              t_n = 1'b0;
    logic [W_DATA-1:0] h;
    logic [W_DATA-1:0] rs_val;
    always_comb begin
        h      = (t_p == t_n) ? h_p : h_n;
        rs_val = r_in ? '0 : '1;
    end
    assign q_out = clk_in ? q_p : q_n;
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            q_p <= INIT_W;
            h_p <= INIT_W;
            t_p <= t_n;
        end else if (r_in || s_in) begin
            q_p <= rs_val;
            h_p <= rs_val;
            t_p <= t_n;
        end else if (!ce_in) begin
            q_p <= q_n;
        end else if (AL_C0) begin
            q_p <= d0_in;
            h_p <= d1_in;
            t_p <= t_n;
        end else if (AL_C1) begin
            q_p <= h;
        end else begin
            q_p <= d0_in;
        end
    end
    always_ff @(negedge clk_in) begin
        if (!n_reset_in) begin
            q_n <= INIT_W;
            h_n <= INIT_W;
            t_n <= ~t_p;
        end else if (r_in || s_in) begin
            q_n <= rs_val;
            h_n <= rs_val;
            t_n <= ~t_p;
        end else if (!ce_in) begin
            q_n <= q_p;
        end else if (AL_C1) begin
            q_n <= d1_in;
            h_n <= d0_in;
            t_n <= ~t_p;
        end else if (AL_C0) begin
            q_n <= h;
        end else begin
            q_n <= d1_in;
        end
    end
endmodule

// File: tb/tb_ddr_out_reg.sv
// tb_ddr_out_reg: directed and random checks of ddr_out_reg in all three alignments
module tb_ddr_out_reg;
    logic       clk_in = 1'b0;
    logic       n_reset_in, ce_in, r_in, s_in;
    logic [7:0] d0, d1;
    logic       q_none;
    logic [7:0] q_c0, q_c1;
    logic [7:0] mq[3];
    logic [7:0] mh[3];
    logic [7:0] last;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk_in = ~clk_in;

    ddr_out_reg #(.W_DATA(1), .DDR_ALIGNMENT("NONE"), .INIT(1'b1)) dut_none (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .ce_in(ce_in),
        .d0_in(d0[0]), .d1_in(d1[0]), .r_in(r_in), .s_in(s_in), .q_out(q_none));
    ddr_out_reg #(.W_DATA(8), .DDR_ALIGNMENT("C0"), .INIT(1'b1)) dut_c0 (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .ce_in(ce_in),
        .d0_in(d0), .d1_in(d1), .r_in(r_in), .s_in(s_in), .q_out(q_c0));
    ddr_out_reg #(.W_DATA(8), .DDR_ALIGNMENT("C1"), .INIT(1'b0)) dut_c1 (
        .clk_in(clk_in), .n_reset_in(n_reset_in), .ce_in(ce_in),
        .d0_in(d0), .d1_in(d1), .r_in(r_in), .s_in(s_in), .q_out(q_c1));

    // Reference: k=0 NONE (bit 0 only), k=1 C0, k=2 C1 (INIT=0).
    function automatic void model_edge(logic e0);
        logic [7:0] init_v;
        for (int k = 0; k < 3; k++) begin
            init_v = (k == 2) ? 8'h00 : 8'hFF;
            if (!n_reset_in) begin
                mq[k] = init_v;
                mh[k] = init_v;
            end else if (r_in) begin
                mq[k] = 8'h00;
                mh[k] = 8'h00;
            end else if (s_in) begin
                mq[k] = 8'hFF;
                mh[k] = 8'hFF;
            end else if (ce_in) begin
                if (k == 0) mq[k] = e0 ? d0 : d1;
                else if (k == 1) begin
                    if (e0) begin
                        mq[k] = d0;
                        mh[k] = d1;
                    end else mq[k] = mh[k];
                end else begin
                    if (!e0) begin
                        mq[k] = d1;
                        mh[k] = d0;
                    end else mq[k] = mh[k];
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0t: observed %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_model();
        chk("none_q", {7'b0, q_none}, {7'b0, mq[0][0]});
        chk("c0_q", q_c0, mq[1]);
        chk("c1_q", q_c1, mq[2]);
    endtask

    task automatic tick();
        @(clk_in);
        model_edge(clk_in);
        #1;
        chk_model();
    endtask

    initial begin
        mq[0] = 8'hFF; mh[0] = 8'hFF;
        mq[1] = 8'hFF; mh[1] = 8'hFF;
        mq[2] = 8'h00; mh[2] = 8'h00;
        n_reset_in = 1'b1; ce_in = 1'b0; r_in = 1'b0; s_in = 1'b0;
        d0 = 8'h00; d1 = 8'hFF;
        #1;
        chk("pwrup_none", {7'b0, q_none}, 8'h01);
        chk("pwrup_c0", q_c0, 8'hFF);
        chk("pwrup_c1", q_c1, 8'h00);
        repeat (3) tick();
        chk("ce0_none", {7'b0, q_none}, 8'h01);
        // clock forwarding
        d0 = 8'h01; d1 = 8'h00; ce_in = 1'b1; s_in = 1'b1;
        repeat (8) begin
            tick();
            chk("fwd_set", {7'b0, q_none}, 8'h01);
        end
        s_in = 1'b0;
        repeat (8) begin
            tick();
            chk("fwd_clk", {7'b0, q_none}, {7'b0, clk_in});
        end
        // C0: d1 captured at E0, later change ignored
        while (clk_in) tick();
        d0 = 8'hA5; d1 = 8'h3C;
        tick();
        chk("c0_d0", q_c0, 8'hA5);
        d1 = 8'hFF;
        tick();
        chk("c0_d1", q_c0, 8'h3C);
        // C1: d0 captured at E1, later change ignored
        while (!clk_in) tick();
        d0 = 8'h11; d1 = 8'h22;
        tick();
        chk("c1_d1", q_c1, 8'h22);
        d0 = 8'h99;
        tick();
        chk("c1_d0", q_c1, 8'h11);
        // priority
        n_reset_in = 1'b0; s_in = 1'b1;
        tick();
        chk("pri_rst_c0", q_c0, 8'hFF);
        chk("pri_rst_c1", q_c1, 8'h00);
        n_reset_in = 1'b1; r_in = 1'b1;
        tick();
        chk("pri_r_c0", q_c0, 8'h00);
        chk("pri_r_none", {7'b0, q_none}, 8'h00);
        r_in = 1'b0; s_in = 1'b0;
        // freeze with ce_in low, then clear during freeze
        d0 = 8'h01; d1 = 8'h00;
        repeat (3) tick();
        ce_in = 1'b0;
        last = {7'b0, q_none};
        repeat (4) begin
            d0 = ~d0; d1 = ~d1;
            tick();
            chk("freeze", {7'b0, q_none}, last);
        end
        r_in = 1'b1;
        tick();
        chk("freeze_r", {7'b0, q_none}, 8'h00);
        r_in = 1'b0; ce_in = 1'b1;
        // random traffic
        repeat (600) begin
            n_reset_in = ($urandom % 16) != 0;
            r_in = ($urandom % 20) == 0;
            s_in = ($urandom % 20) == 0;
            ce_in = ($urandom % 5) != 0;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddr_out_reg.md
# ddr_out_reg

Single-clock, double-data-rate output register with synchronous set and reset. On each rising edge of `clk_in` it drives one data word onto `q_out`, and on each falling edge it drives a second word. It sits at the FPGA boundary and feeds pins such as a forwarded serial clock. Example: with `d0_in=1`, `d1_in=0` and `s_in` used as a gate, `q_out` is a copy of `clk_in` that parks high.

## Interface
Parameters:
- `W_DATA`, default 1: width of the data path.
- `DDR_ALIGNMENT`, default "NONE": input sampling alignment. Legal values are "NONE", "C0" and "C1". Any other value behaves as "NONE".
- `INIT`, default 1'b1: value of every `q_out` bit at power-up and after reset.

Ports:
- `clk_in`, input, 1: the only clock. Rising edges are E0 and falling edges are E1.
- `n_reset_in`, input, 1: synchronous, active-low reset. It is sampled at both E0 and E1.
- `ce_in`, input, 1: clock enable for the data path.
- `d0_in`, input, `W_DATA`: word driven in the E0 phase (clock high).
- `d1_in`, input, `W_DATA`: word driven in the E1 phase (clock low).
- `r_in`, input, 1: synchronous reset of the output, active-high. Forces all `q_out` bits to 0.
- `s_in`, input, 1: synchronous set of the output, active-high. Forces all `q_out` bits to 1.
- `q_out`, output, `W_DATA`: registered DDR output.

## Operation
- At each edge (E0 or E1), the first matching rule below applies:
  1. `n_reset_in`=0: `q_out` becomes `INIT`, and all internal holding registers become `INIT`.
  2. `r_in`=1: `q_out` becomes all 0, and the holding registers become all 0.
  3. `s_in`=1: `q_out` becomes all 1, and the holding registers become all 1.
  4. `ce_in`=0: `q_out` and the holding registers keep their values.
  5. Otherwise the data rule for the active alignment applies (below).
- `r_in`, `s_in` and `n_reset_in` act regardless of `ce_in`.
- `r_in` and `s_in` both high: reset wins.
- Data rule for "NONE":
  - E0: `q_out` takes `d0_in`.
  - E1: `q_out` takes `d1_in`.
  - No holding register is used.
- Data rule for "C0":
  - E0: `d0_in` and `d1_in` are both sampled. `q_out` takes the sampled `d0_in`, and the sampled `d1_in` is stored in the holding register `h1`.
  - E1: `q_out` takes `h1`. The live `d1_in` at E1 is ignored.
- Data rule for "C1":
  - E1: `d0_in` and `d1_in` are both sampled. `q_out` takes the sampled `d1_in`, and the sampled `d0_in` is stored in the holding register `h0`.
  - E0: `q_out` takes `h0`. The live `d0_in` at E0 is ignored.
- Holding registers in "C0"/"C1":
  - Updated only at their sampling edge.
  - A reset or set at either edge overwrites them, so the next output phase drives the forced value.
  - `ce_in`=0 at the sampling edge freezes them. `ce_in`=0 at the output edge freezes `q_out` even if a held word is pending.
- Power-up state: `q_out` and all holding registers equal `INIT`.
- Reset mid-operation: a reset takes effect at the first edge where `n_reset_in` is sampled low. Normal DDR output resumes at the first edge after it is sampled high. For "C0", this first edge must be an E0 to load fresh data; until then `q_out` keeps `INIT`.

## Timing
- `q_out` changes only at E0 or E1, and only after the edge.
- "NONE": the word sampled at an edge is visible at that same edge. Latency is 0 half-cycles.
- "C0":
  - `d0_in` appears at the E0 where it was sampled.
  - `d1_in` appears one half-cycle later, at the next E1.
- "C1":
  - `d1_in` appears at the E1 where it was sampled.
  - `d0_in` appears one half-cycle later, at the next E0.
- `r_in`, `s_in` and `n_reset_in` take effect at the first edge where they are sampled active. They stay effective at every edge while held active.
- There is no handshake. With `ce_in` tied high, one word is delivered per half-cycle.

## Test plan
- Power-up, "NONE", `W_DATA`=1, `INIT`=1, `ce_in`=0 → `q_out`=1 until the first enabled edge.
- Clock forwarding, "NONE": `d0_in`=1, `d1_in`=0, `ce_in`=1, `s_in`=1 for 4 cycles, then 0.
  - While `s_in`=1: `q_out` held at 1.
  - After `s_in` drops: `q_out`=1 after each rise and 0 after each fall, for 8 half-cycles.
- Alignment "C0", `W_DATA`=8: at one E0 apply `d0_in`=0xA5, `d1_in`=0x3C, then change `d1_in` to 0xFF before the following E1.
  - `q_out`=0xA5 after that E0.
  - `q_out`=0x3C after the next E1 (0xFF is ignored).
- Alignment "C1", `W_DATA`=8: at one E1 apply `d0_in`=0x11, `d1_in`=0x22.
  - `q_out`=0x22 after that E1.
  - `q_out`=0x11 after the next E0.
- Priority: `n_reset_in`=0 together with `s_in`=1 → `q_out`=`INIT`. Then `n_reset_in`=1 with `r_in`=1 and `s_in`=1 → `q_out`=0 at the next edge.
- `ce_in`=0 mid-stream, "NONE", with `d0_in` and `d1_in` toggling → `q_out` frozen at its last value. Asserting `r_in` during the freeze → `q_out`=0 at the next edge.
